adder_share_arbiter: RTL and testbench

Arbitrates one shared 3-bit adder datapath (`sayi1`/`sayi2` in, 4-bit carry+sum out) among `NUM_REQ` requesters.
- Runs one transaction at a time: accept operands, drive the shared adder, register its 4-bit result, and return it with the requester ID over a valid/ready response channel.
- Sits between the lab's operand sources and the single `Adder3Bit` instance, so the adder is never duplicated.

---
 rtl/adder_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Shares a single external 3-bit adder (Adder3Bit: sayi1/sayi2 -> 4-bit
// carry+sum) among NUM_REQ requesters. The block handles one transaction at a
// time. It grants one requester and latches that requester's operands. It
// drives the shared adder, registers the adder result, and returns the result
// with the requester ID over a valid/ready response channel.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin grant starting at a pointer
//                       undefined -> fixed priority, lowest index wins
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   IDW      requester ID width, ceil(log2(NUM_REQ))
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester valid
//   req_a      operand A, requester i in bits [3i+2:3i]
//   req_b      operand B, same packing as req_a
//   req_ready  one-hot grant (combinational, only in IDLE)
//   add_a      to adder sayi1
//   add_b      to adder sayi2
//   add_sum    from adder sum (combinational carry+sum)
//   rsp_valid  response valid
//   rsp_sum    registered carry+sum
//   rsp_id     requester that owns the response
//   rsp_ready  response accepted
//   done_cnt   completed transactions, wraps at 256
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_a,
  input  logic [3*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [2:0]           add_a,
  output logic [2:0]           add_b,
  input  logic [3:0]           add_sum,
  output logic                 rsp_valid,
  output logic [3:0]           rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic [7:0]           done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [2:0]     grant_a;
  logic [2:0]     grant_b;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]     ptr;
  logic [2*NUM_REQ-1:0] rotated;
  int                 slot;

  // Rotate the request vector so that bit 0 is the pointer position. The
  // first set bit k then maps back to requester (ptr + k) mod NUM_REQ.
  assign rotated = {req_valid, req_valid} >> ptr;

  // NOTE: every variable gets a default before any conditional assignment,
  // so no path through the block leaves a value held and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    slot      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        slot = int'(ptr) + k;
        if (slot >= NUM_REQ) slot = slot - NUM_REQ;
        grant_idx = IDW'(slot);
        grant_any = 1'b1;
      end
    end
  end
`else
  // Fixed priority. The descending scan leaves the lowest asserted index.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_idx = IDW'(i);
        grant_any = 1'b1;
      end
    end
  end
`endif

  // Operand mux for the granted requester.
  assign grant_a = 3'(req_a >> (3 * grant_idx));
  assign grant_b = 3'(req_b >> (3 * grant_idx));

  // The grant is only offered while idle. It is also masked by rst. Reset
  // forces the state to IDLE asynchronously, and the grant must still read
  // zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_any)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: all registers here are control or datapath flops. None is a memory
  // array, so each one gets an explicit reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      done_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // add_a/add_b keep their previous values until a new grant.
          if (grant_any) begin
            add_a  <= grant_a;
            add_b  <= grant_b;
            rsp_id <= grant_idx;
            state  <= CALC;
          end
        end
        CALC: begin
          // This is the only edge on which add_sum is sampled.
          rsp_sum   <= add_sum;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
            // rsp_id still holds this transaction's grant index.
            ptr <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + IDW'(1);
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Self-checking bench for adder_share_arbiter. The bench models the shared
// adder combinationally. Each stimulus task pushes the expected {id, sum} of
// every request it issues onto a scoreboard queue. The queue is popped and
// compared whenever the DUT completes a response handshake.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [3:0]     sum;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_a;
  logic [3*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           add_a;
  logic [2:0]           add_b;
  logic [3:0]           add_sum;
  logic                 rsp_valid;
  logic [3:0]           rsp_sum;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready;
  logic [7:0]           done_cnt;

  int                   checks = 0;
  int                   errors = 0;
  exp_t                 sbq[$];
  logic [NUM_REQ-1:0]   sticky;  // requesters that keep valid after a grant

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .done_cnt  (done_cnt)
  );

  // Stand-in for the shared Adder3Bit.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // Advance to the falling edge. Score any response that completes its
  // handshake on the following rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d sum=%b expected no response", rsp_id, rsp_sum);
      end else begin
        e = sbq.pop_front();
        if (rsp_id !== e.id || rsp_sum !== e.sum) begin
          errors++;
          $display("FAIL rsp: got id=%0d sum=%b expected id=%0d sum=%b",
                   rsp_id, rsp_sum, e.id, e.sum);
        end
      end
    end
  endtask

  // Move to just after a rising edge. All new stimulus starts here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic [3:0] sum);
    exp_t e;
    e.id  = IDW'(id);
    e.sum = sum;
    sbq.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [2:0] a, input logic [2:0] b,
                         input bit push);
    req_a[3*id +: 3] = a;
    req_b[3*id +: 3] = b;
    req_valid[id]    = 1'b1;
    if (push) push_exp(id, {1'b0, a} + {1'b0, b});
  endtask

  // Run clocks until n grants are seen. If drain is set, also wait until the
  // scoreboard and the response channel are empty. Non-sticky requesters
  // drop valid after their own grant.
  task automatic run_until(input int n, input bit drain, input int budget);
    logic [NUM_REQ-1:0] g;
    int grants = 0;
    int cyc    = 0;
    bit fin    = 1'b0;
    while (!fin) begin
      tick();
      g = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (g != '0) grants++;
      req_valid = req_valid & ~(g & ~sticky);
      cyc++;
      if (grants >= n && (!drain || (sbq.size() == 0 && !rsp_valid))) begin
        fin = 1'b1;
      end else if (cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d grants queue=%0d expected %0d grants and empty queue",
                 grants, sbq.size(), n);
        sbq.delete();
        req_valid = '0;
        fin = 1'b1;
      end
    end
  endtask

  task automatic wait_rsp_valid(input int budget);
    int cyc = 0;
    while (!rsp_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL wait_rsp_valid: got rsp_valid=0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    sticky    = '0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;  // the grant must stay low even with requests present
    req_a     = 12'hFFF;
    req_b     = 12'hFFF;
    rsp_ready = 1'b0;
    sticky    = '0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 4'd0) begin errors++; $display("FAIL reset_rsp_sum: got %b expected 0000", rsp_sum); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (add_a !== 3'd0) begin errors++; $display("FAIL reset_add_a: got %b expected 000", add_a); end
    checks++; if (add_b !== 3'd0) begin errors++; $display("FAIL reset_add_b: got %b expected 000", add_b); end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d expected 0", done_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  // One request with rsp_ready tied high. Covers the grant-to-valid latency.
  task automatic test_single();
    step();
    rsp_ready = 1'b1;
    set_req(0, 3'b101, 3'b001, 1'b1);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    @(posedge clk);  // grant edge T
    #1;
    req_valid[0] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc_valid: got %b expected 0", rsp_valid); end
    checks++; if (add_a !== 3'b101 || add_b !== 3'b001) begin errors++; $display("FAIL single_operands: got %b/%b expected 101/001", add_a, add_b); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_calc_ready: got %b expected 0000", req_ready); end
    tick();  // after T+1: response up and scored here
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    tick();  // after the handshake edge
    checks++; if (done_cnt !== 8'd1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_carry();
    step();
    set_req(2, 3'b111, 3'b110, 1'b1);  // 1101
    run_until(1, 1'b1, 20);
    set_req(2, 3'b100, 3'b111, 1'b1);  // 1011
    run_until(1, 1'b1, 20);
  endtask

  // All four requesters at once. Each drops valid after its own grant, so
  // both arbitration builds serve 0,1,2,3 in order.
  task automatic test_contention();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i + 1), 3'(2 * i), 1'b1);
    run_until(NUM_REQ, 1'b1, 40);
    checks++; if (done_cnt !== 8'd4) begin errors++; $display("FAIL contention_done_cnt: got %0d expected 4", done_cnt); end
  endtask

  // Requesters 1 and 3 hold valid continuously.
  task automatic test_hold();
    step();
`ifdef ARB_ROUND_ROBIN_EN
    // The pointer is 0 after requester 3's handshake, so the grants alternate.
    sticky = 4'b1010;
    set_req(1, 3'd1, 3'd2, 1'b0);
    set_req(3, 3'd7, 3'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_exp(1, 4'd3);
      push_exp(3, 4'd14);
    end
    run_until(6, 1'b0, 60);
    req_valid = '0;
    sticky    = '0;
    run_until(0, 1'b1, 20);
`else
    // Fixed priority: requester 1 always wins and requester 3 starves.
    sticky = 4'b0010;
    set_req(1, 3'd1, 3'd2, 1'b0);
    set_req(3, 3'd7, 3'd7, 1'b0);
    for (int k = 0; k < 6; k++) push_exp(1, 4'd3);
    run_until(6, 1'b0, 60);
    req_valid[1] = 1'b0;
    sticky       = '0;
    push_exp(3, 4'd14);
    run_until(1, 1'b1, 20);
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] base;
    step();
    rsp_ready = 1'b0;
    set_req(1, 3'd3, 3'd4, 1'b1);
    run_until(1, 1'b0, 10);
    wait_rsp_valid(10);
    base = done_cnt;
    set_req(0, 3'd1, 3'd1, 1'b1);  // must wait for the handshake
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, rsp_valid); end
      checks++; if (rsp_sum !== 4'd7) begin errors++; $display("FAIL bp_sum[%0d]: got %b expected 0111", c, rsp_sum); end
      checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_id[%0d]: got %0d expected 1", c, rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
      checks++; if (done_cnt !== base) begin errors++; $display("FAIL bp_done_cnt[%0d]: got %0d expected %0d", c, done_cnt, base); end
    end
    step();
    rsp_ready = 1'b1;
    run_until(1, 1'b1, 20);
    checks++; if (done_cnt !== base + 8'd2) begin errors++; $display("FAIL bp_done_after: got %0d expected %0d", done_cnt, base + 8'd2); end
  endtask

  task automatic test_reset_mid();
    step();
    rsp_ready = 1'b0;
    set_req(2, 3'b011, 3'b101, 1'b0);  // discarded by reset, never expected
    run_until(1, 1'b0, 10);
    wait_rsp_valid(10);
    checks++; if (rsp_sum !== 4'b1000) begin errors++; $display("FAIL mid_sum: got %b expected 1000", rsp_sum); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL mid_id: got %0d expected 2", rsp_id); end
    rst       = 1'b1;
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 4'd0) begin errors++; $display("FAIL mid_rst_sum: got %b expected 0000", rsp_sum); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL mid_rst_id: got %0d expected 0", rsp_id); end
    checks++; if (add_a !== 3'd0 || add_b !== 3'd0) begin errors++; $display("FAIL mid_rst_add: got %b/%b expected 000/000", add_a, add_b); end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_done_cnt: got %0d expected 0", done_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    tick();
    req_valid = '0;
    step();
    rst = 1'b0;
    set_req(1, 3'b010, 3'b010, 1'b1);  // 0100 from requester 1
    run_until(1, 1'b1, 20);
    checks++; if (done_cnt !== 8'd1) begin errors++; $display("FAIL mid_after_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      set_req(k % NUM_REQ, 3'(k % 8), 3'((k / 8) % 8), 1'b1);
      run_until(1, 1'b1, 20);
      if (k == 254) begin
        checks++; if (done_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", done_cnt); end
      end
    end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", done_cnt); end
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    sticky    = '0;
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_hold();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
